// File: rtl/div_pkg.sv
// Shared types and constants for the sequential signed divider.
package div_pkg;

  typedef enum logic [1:0] {IDLE, DIVIDE, FIXUP, DONE} state_t;

  localparam int DEF_WIDTH = 32;

  // Saturation and divide-by-zero quotients at the default width
  localparam logic [DEF_WIDTH-1:0] QMAX  = {1'b0, {(DEF_WIDTH-1){1'b1}}};
  localparam logic [DEF_WIDTH-1:0] QMIN  = {1'b1, {(DEF_WIDTH-1){1'b0}}};
  localparam logic [DEF_WIDTH-1:0] QDIV0 = {DEF_WIDTH{1'b1}};

endpackage

// File: rtl/div_magnitude.sv
// Conditional two's-complement negation; used for operand abs and result sign fix-up.
module div_magnitude #(
  parameter int W = 32
) (
  input  logic [W-1:0] value,
  input  logic         en,
  output logic [W-1:0] result
);

  assign result = en ? (~value + W'(1)) : value;

endmodule

// File: rtl/seq_signed_divider.sv
// Restoring signed divider, 2W/W -> W quotient + W remainder, one quotient bit per clock.
// Optional SEQ_DIV_EARLY_OUT_EN skips the iteration when |dividend| < |divisor|.
module seq_signed_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2*WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic [WIDTH-1:0]     quotient,
  output logic [WIDTH-1:0]     remainder,
  output logic                 busy,
  output logic                 done,
  output logic                 div_by_zero,
  output logic                 overflow
);

  localparam int DW = 2*WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t state, state_nx;

  logic [WIDTH-1:0] rem, qsh;
  logic [WIDTH:0]   dvs;
  logic [CW-1:0]    cnt;
  logic             q_neg, r_neg;

  // Dividend magnitude is one bit wider so -2^(2W-1) stays representable
  logic [DW:0]    dvd_mag;
  logic [WIDTH:0] dvs_mag;

  div_magnitude #(.W(DW+1)) u_abs_dvd (
    .value ({dividend[DW-1], dividend}),
    .en    (dividend[DW-1]),
    .result(dvd_mag)
  );

  div_magnitude #(.W(WIDTH+1)) u_abs_dvs (
    .value ({divisor[WIDTH-1], divisor}),
    .en    (divisor[WIDTH-1]),
    .result(dvs_mag)
  );

  logic dz_in, pre_ovf, early_in;
  assign dz_in   = (divisor == '0);
  assign pre_ovf = !dz_in && (dvd_mag[DW:WIDTH] >= dvs_mag);
`ifdef SEQ_DIV_EARLY_OUT_EN
  assign early_in = !dz_in && (dvd_mag[DW:WIDTH] == '0) &&
                    ({1'b0, dvd_mag[WIDTH-1:0]} < dvs_mag);
`else
  assign early_in = 1'b0;
`endif

  // One restoring step: shift in next dividend bit, trial-subtract |divisor|
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic             bit_q;
  logic [WIDTH-1:0] rem_nx;
  logic             trial_unused;

  assign shifted      = {rem, qsh[WIDTH-1]};
  assign trial        = {1'b0, shifted} - {1'b0, dvs};
  assign bit_q        = ~trial[WIDTH+1];
  assign rem_nx       = bit_q ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign trial_unused = trial[WIDTH];

  logic [WIDTH-1:0] q_signed, r_signed;
  logic             range_ovf;

  div_magnitude #(.W(WIDTH)) u_neg_q (
    .value (qsh),
    .en    (q_neg),
    .result(q_signed)
  );

  div_magnitude #(.W(WIDTH)) u_neg_r (
    .value (rem),
    .en    (r_neg),
    .result(r_signed)
  );

  assign range_ovf = q_neg ? (qsh > SAT_NEG) : qsh[WIDTH-1];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (dz_in)                    state_nx = DONE;
          else if (pre_ovf || early_in) state_nx = FIXUP;
          else                          state_nx = DIVIDE;
        end
      end
      DIVIDE: begin
        busy = 1'b1;
        if (cnt == '0) state_nx = FIXUP;
      end
      FIXUP: begin
        busy     = 1'b1;
        state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem         <= '0;
      qsh         <= '0;
      dvs         <= '0;
      cnt         <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dvs         <= dvs_mag;
            q_neg       <= dividend[DW-1] ^ divisor[WIDTH-1];
            r_neg       <= dividend[DW-1];
            cnt         <= CW'(WIDTH-1);
            overflow    <= pre_ovf;
            div_by_zero <= dz_in;
            if (early_in) begin
              rem <= dvd_mag[WIDTH-1:0];
              qsh <= '0;
            end else begin
              rem <= dvd_mag[DW-1:WIDTH];
              qsh <= dvd_mag[WIDTH-1:0];
            end
            if (dz_in) begin
              quotient  <= '1;
              remainder <= dividend[WIDTH-1:0];
            end
          end
        end
        DIVIDE: begin
          rem <= rem_nx;
          qsh <= {qsh[WIDTH-2:0], bit_q};
          cnt <= cnt - CW'(1);
        end
        FIXUP: begin
          if (overflow || range_ovf) begin
            overflow  <= 1'b1;
            quotient  <= q_neg ? SAT_NEG : SAT_POS;
            remainder <= '0;
          end else begin
            quotient  <= q_signed;
            remainder <= r_signed;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
